disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the digital clock's common-anode seven-segment bank. It holds the refresh timer, steps a digit index across `NUM_DIGITS` positions, and drives one active-low anode per slot. It decodes the selected BCD digit to active-low segment lines, with a programmable blanking gap between slots to suppress ghosting. It sits between the timekeeping counters (BCD source) and the display pins.

---
 rtl/disp_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed seven-segment scan controller.
// Blanked slot timing, BCD decode and active-low anode/segment drive.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_bcd,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [IW-1:0]   idx_nx;
    logic            load;
    logic            tick_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic [3:0]      bcd_sel;
    logic            dp_sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Next state, slot counter, digit index and slot-start load strobe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = digit_idx;
        load     = 1'b0;
        tick_nx  = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    load     = 1'b1;
                end
                BLANK: begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        load     = 1'b1;
                        if (digit_idx == IDX_LAST) begin
                            idx_nx  = '0;
                            tick_nx = 1'b1;
                        end else begin
                            idx_nx = digit_idx + 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Output values for the upcoming cycle, derived from next state.
    always_comb begin
        an_nx = '1;
        if (state_nx == SHOW) begin
            an_nx[idx_nx] = 1'b0;
        end
        bcd_sel = digits_bcd[{idx_nx, 2'b00} +: 4];
        dp_sel  = dp_in[idx_nx];
    end

    // State register, slot counter and digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            digit_idx <= idx_nx;
        end
    end

    // Registered pin drive; segments change only when a slot begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nx;
            frame_tick <= tick_nx;
            if (state_nx == IDLE) begin
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else if (load) begin
                seg <= seg_decode(bcd_sel);
                dp  <= ~dp_sel;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for the display scan controller.
// Expected pin states are queued per cycle and compared after each edge.
module tb_disp_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [4*N-1:0] digits_bcd = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic [1:0]     digit_idx;
    logic           frame_tick;

    typedef struct {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic [1:0]   idx;
        logic         tick;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int age = -1;

    logic [4*N-1:0] d_v = '0;
    logic [N-1:0]   p_v = '0;
    logic [6:0]     seg_m = 7'h7F;
    logic           dp_m = 1'b1;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    disp_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits_bcd(digits_bcd),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the pin state expected after
    // the following rising edge. The model counts cycles since enable.
    task automatic cyc(input logic r, input logic e);
        exp_t x;
        int pos;
        int idx;
        @(negedge clk);
        rst_n      = r;
        en         = e;
        digits_bcd = d_v;
        dp_in      = p_v;
        if (!r || !e) begin
            age    = -1;
            seg_m  = 7'h7F;
            dp_m   = 1'b1;
            x.an   = '1;
            x.seg  = 7'h7F;
            x.dp   = 1'b1;
            x.idx  = 2'd0;
            x.tick = 1'b0;
        end else begin
            age++;
            pos = age % R;
            idx = (age / R) % N;
            if (pos == 0) begin
                seg_m = seg_tab[d_v[4*idx +: 4]];
                dp_m  = ~p_v[idx];
            end
            x.an   = (pos < B) ? 4'hF : ~(4'b0001 << idx);
            x.seg  = seg_m;
            x.dp   = dp_m;
            x.idx  = 2'(idx);
            x.tick = (age > 0) && (age % (N * R) == 0);
        end
        sb.push_back(x);
    endtask

    // Pop one expectation per edge and compare every output.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("an", 32'(an), 32'(x.an));
                check("seg", 32'(seg), 32'(x.seg));
                check("dp", 32'(dp), 32'(x.dp));
                check("digit_idx", 32'(digit_idx), 32'(x.idx));
                check("frame_tick", 32'(frame_tick), 32'(x.tick));
            end
        end
    end

    initial begin : stim
        d_v = 16'h1234;
        p_v = 4'b0000;
        repeat (3) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);

        repeat (104) cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0);

        d_v = 16'h123A;
        p_v = 4'b0001;
        repeat (16) cyc(1'b1, 1'b1);
        repeat (6) cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);

        d_v = 16'h5678;
        p_v = 4'b0000;
        repeat (12) cyc(1'b1, 1'b1);
        d_v = 16'h9999;
        repeat (38) cyc(1'b1, 1'b1);

        repeat (2) cyc(1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
